// File: rtl/dtcm_rib_arbiter_pkg.sv
// Shared definitions for the DTCM RIB arbiter: FSM encoding, master ids,
// RIB field widths and the request bundle used by the field mux.
package dtcm_rib_arbiter_pkg;

  localparam int RIB_AW = 32;
  localparam int RIB_DW = 32;
  localparam int RIB_MW = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2
  } rib_state_e;

  localparam logic M_CORE = 1'b0;
  localparam logic M_DMA  = 1'b1;

  typedef struct packed {
    logic [RIB_AW-1:0] addr;
    logic              wrcs;
    logic [RIB_MW-1:0] mask;
    logic [RIB_DW-1:0] wdata;
  } rib_req_t;

  function automatic rib_req_t rib_pack(
    input logic [RIB_AW-1:0] addr,
    input logic              wrcs,
    input logic [RIB_MW-1:0] mask,
    input logic [RIB_DW-1:0] wdata
  );
    rib_req_t r;
    r.addr  = addr;
    r.wrcs  = wrcs;
    r.mask  = mask;
    r.wdata = wdata;
    return r;
  endfunction

endpackage

// File: rtl/dtcm_rib_arbiter_rr_pick2.sv
// Combinational two-way round-robin selector: on a tie the master that did
// not own the previous transaction wins.
module rib_rr_pick2
  import dtcm_rib_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_owner,
  output logic       sel,
  output logic       any
);

  // Select the requester; a tie goes to the non-previous owner.
  always_comb begin
    sel = M_CORE;
    any = |req;
    case (req)
      2'b01:   sel = M_CORE;
      2'b10:   sel = M_DMA;
      2'b11:   sel = ~last_owner;
      default: sel = M_CORE;
    endcase
  end

endmodule

// File: rtl/dtcm_rib_arbiter.sv
// Two-master arbiter in front of the single-ported DTCM RIB slave. One
// transaction in flight; the response is buffered until the owner accepts it.
module dtcm_rib_arbiter
  import dtcm_rib_arbiter_pkg::*;
#(
  parameter int unsigned RSP_TIMEOUT = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [RIB_AW-1:0] i_m0_addr,
  input  logic              i_m0_wrcs,
  input  logic [RIB_MW-1:0] i_m0_mask,
  input  logic [RIB_DW-1:0] i_m0_wdata,
  input  logic              i_m0_req,
  output logic              o_m0_gnt,
  output logic              o_m0_rsp,
  output logic [RIB_DW-1:0] o_m0_rdata,
  input  logic              i_m0_rdy,
  input  logic [RIB_AW-1:0] i_m1_addr,
  input  logic              i_m1_wrcs,
  input  logic [RIB_MW-1:0] i_m1_mask,
  input  logic [RIB_DW-1:0] i_m1_wdata,
  input  logic              i_m1_req,
  output logic              o_m1_gnt,
  output logic              o_m1_rsp,
  output logic [RIB_DW-1:0] o_m1_rdata,
  input  logic              i_m1_rdy,
  output logic [RIB_AW-1:0] o_s_addr,
  output logic              o_s_wrcs,
  output logic [RIB_MW-1:0] o_s_mask,
  output logic [RIB_DW-1:0] o_s_wdata,
  output logic              o_s_req,
  input  logic              i_s_gnt,
  input  logic              i_s_rsp,
  input  logic [RIB_DW-1:0] i_s_rdata,
  output logic              o_s_rdy,
  output logic              o_err
);

  localparam int unsigned CNT_W = (RSP_TIMEOUT > 32'd0) ? $clog2(RSP_TIMEOUT + 32'd1) : 1;
  localparam logic [CNT_W-1:0] TO_LOAD  = CNT_W'(RSP_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic             TO_EN    = (RSP_TIMEOUT != 32'd0) ? 1'b1 : 1'b0;
  localparam logic [RIB_DW-1:0] DATA_ZERO = {RIB_DW{1'b0}};

  rib_state_e        state_r;
  logic              owner_r;
  logic              last_owner_r;
  logic [RIB_DW-1:0] rbuf_r;
  logic [CNT_W-1:0]  tmo_cnt_r;

  logic              sel_s;
  logic              any_s;
  logic              grant_s;
  logic              owner_rdy_s;
  logic              timeout_s;
  logic              rsp_act_s;
  logic [RIB_DW-1:0] rsp_data_s;
  rib_req_t          m0_fields_s;
  rib_req_t          m1_fields_s;
  rib_req_t          sel_fields_s;

  rib_rr_pick2 u_pick (
    .req        ({i_m1_req, i_m0_req}),
    .last_owner (last_owner_r),
    .sel        (sel_s),
    .any        (any_s)
  );

  assign o_s_rdy = 1'b1;

  // Request path: mux the selected master onto the slave and route its grant.
  always_comb begin
    m0_fields_s = rib_pack(i_m0_addr, i_m0_wrcs, i_m0_mask, i_m0_wdata);
    m1_fields_s = rib_pack(i_m1_addr, i_m1_wrcs, i_m1_mask, i_m1_wdata);
    if (sel_s == M_DMA) begin
      sel_fields_s = m1_fields_s;
    end else begin
      sel_fields_s = m0_fields_s;
    end
    o_s_addr  = sel_fields_s.addr;
    o_s_wrcs  = sel_fields_s.wrcs;
    o_s_mask  = sel_fields_s.mask;
    o_s_wdata = sel_fields_s.wdata;
    // Gated by reset so nothing leaks to the DTCM while reset is held.
    o_s_req   = i_rst_n & any_s & (state_r == ST_IDLE);
    grant_s   = o_s_req & i_s_gnt;
    o_m0_gnt  = grant_s & (sel_s == M_CORE);
    o_m1_gnt  = grant_s & (sel_s == M_DMA);
  end

  // Response path: live slave data in WAIT, buffered data in HOLD.
  always_comb begin
    timeout_s  = 1'b0;
    rsp_act_s  = 1'b0;
    rsp_data_s = DATA_ZERO;
    case (state_r)
      ST_WAIT: begin
        timeout_s = TO_EN & ~i_s_rsp & (tmo_cnt_r == CNT_ONE);
        rsp_act_s = i_s_rsp | timeout_s;
        if (i_s_rsp) begin
          rsp_data_s = i_s_rdata;
        end else begin
          rsp_data_s = DATA_ZERO;
        end
      end
      ST_HOLD: begin
        rsp_act_s  = 1'b1;
        rsp_data_s = rbuf_r;
      end
      default: begin
        rsp_act_s  = 1'b0;
        rsp_data_s = DATA_ZERO;
      end
    endcase
    if (owner_r == M_DMA) begin
      owner_rdy_s = i_m1_rdy;
    end else begin
      owner_rdy_s = i_m0_rdy;
    end
    o_m0_rsp   = rsp_act_s & (owner_r == M_CORE);
    o_m1_rsp   = rsp_act_s & (owner_r == M_DMA);
    o_m0_rdata = o_m0_rsp ? rsp_data_s : DATA_ZERO;
    o_m1_rdata = o_m1_rsp ? rsp_data_s : DATA_ZERO;
    o_err      = timeout_s;
  end

  // Transaction FSM with owner tracking, timeout counter and response buffer.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r      <= ST_IDLE;
      owner_r      <= M_CORE;
      last_owner_r <= M_DMA;
      rbuf_r       <= DATA_ZERO;
      tmo_cnt_r    <= CNT_ZERO;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (grant_s) begin
            state_r      <= ST_WAIT;
            owner_r      <= sel_s;
            last_owner_r <= sel_s;
            tmo_cnt_r    <= TO_LOAD;
          end
        end
        ST_WAIT: begin
          if (tmo_cnt_r != CNT_ZERO) begin
            tmo_cnt_r <= tmo_cnt_r - CNT_ONE;
          end
          if (rsp_act_s) begin
            if (owner_rdy_s) begin
              state_r <= ST_IDLE;
            end else begin
              state_r <= ST_HOLD;
              rbuf_r  <= rsp_data_s;
            end
          end
        end
        ST_HOLD: begin
          // A late slave response here is deliberately not looked at.
          if (owner_rdy_s) begin
            state_r <= ST_IDLE;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
